// File: rtl/multi_slave_wrr_scheduler.sv
// rtl/multi_slave_wrr_scheduler.sv - three-master weighted round-robin bridge onto a 4-phase slave port
module multi_slave_wrr_scheduler #(
    parameter int unsigned W0      = 2,
    parameter int unsigned W1      = 1,
    parameter int unsigned W2      = 1,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  m_req,
    input  logic [31:0] m_data0,
    input  logic [31:0] m_data1,
    input  logic [31:0] m_data2,
    output logic [2:0]  m_ack,
    output logic        s_req,
    output logic [31:0] s_data,
    output logic        s_sel,
    input  logic        s_ack,
    output logic [1:0]  grant_id,
    output logic        busy,
    output logic        timeout_err,
    output logic [7:0]  err_count
);

    localparam logic [1:0] WT0      = (W0 == 0) ? 2'd1 : 2'(W0);
    localparam logic [1:0] WT1      = (W1 == 0) ? 2'd1 : 2'(W1);
    localparam logic [1:0] WT2      = (W2 == 0) ? 2'd1 : 2'(W2);
    localparam logic [7:0] TMR_LAST = 8'(TIMEOUT - 1);
    localparam logic [1:0] NO_GRANT = 2'd3;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        GRANT = 3'd1,
        SREQ  = 3'd2,
        SREL  = 3'd3,
        MACK  = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  ptr_q, ptr_d;
    logic [1:0]  credit_q [3];
    logic [1:0]  credit_d [3];
    logic [7:0]  timer_q, timer_d;
    logic [1:0]  grant_q, grant_d;
    logic [31:0] s_data_q, s_data_d;
    logic        s_sel_q, s_sel_d;
    logic        terr_q, terr_d;
    logic [7:0]  err_q, err_d;

    logic [1:0]  cand0, cand1, cand2;
    logic [1:0]  winner;
    logic [31:0] granted_data;
    logic [7:0]  err_inc;

    function automatic logic [1:0] inc3(input logic [1:0] v);
        return (v == 2'd2) ? 2'd0 : v + 2'd1;
    endfunction

    function automatic logic [1:0] weight_of(input logic [1:0] g);
        case (g)
            2'd0:    return WT0;
            2'd1:    return WT1;
            default: return WT2;
        endcase
    endfunction

    // Rotating priority: ptr first, then the next two masters in order.
    always_comb begin
        cand0 = ptr_q;
        cand1 = inc3(cand0);
        cand2 = inc3(cand1);
        if (m_req[cand0])      winner = cand0;
        else if (m_req[cand1]) winner = cand1;
        else                   winner = cand2;
    end

    always_comb begin
        case (grant_q)
            2'd0:    granted_data = m_data0;
            2'd1:    granted_data = m_data1;
            default: granted_data = m_data2;
        endcase
    end

    assign err_inc = (err_q == 8'hFF) ? err_q : err_q + 8'd1;

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        credit_d = credit_q;
        timer_d  = timer_q;
        grant_d  = grant_q;
        s_data_d = s_data_q;
        s_sel_d  = s_sel_q;
        terr_d   = 1'b0;
        err_d    = err_q;
        case (state_q)
            IDLE: begin
                if (|m_req) begin
                    grant_d = winner;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                s_data_d = granted_data;
                s_sel_d  = granted_data[31];
                timer_d  = 8'd0;
                state_d  = SREQ;
            end
            SREQ: begin
                if (s_ack) begin
                    timer_d = 8'd0;
                    state_d = SREL;
                end else if (timer_q == TMR_LAST) begin
                    timer_d = 8'd0;
                    terr_d  = 1'b1;
                    err_d   = err_inc;
                    state_d = SREL;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            SREL: begin
                if (!s_ack) begin
                    timer_d = 8'd0;
                    state_d = MACK;
                end else if (timer_q == TMR_LAST) begin
                    timer_d = 8'd0;
                    terr_d  = 1'b1;
                    err_d   = err_inc;
                    state_d = MACK;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            MACK: begin
                // Credit is charged on every completed handshake, timed out or not.
                if (!m_req[grant_q]) begin
                    if (credit_q[grant_q] > 2'd1) begin
                        credit_d[grant_q] = credit_q[grant_q] - 2'd1;
                    end else begin
                        credit_d[grant_q] = weight_of(grant_q);
                        ptr_d             = inc3(grant_q);
                    end
                    grant_d = NO_GRANT;
                    state_d = IDLE;
                end
            end
            default: begin
                grant_d = NO_GRANT;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= 2'd0;
            credit_q[0] <= WT0;
            credit_q[1] <= WT1;
            credit_q[2] <= WT2;
            timer_q     <= 8'd0;
            grant_q     <= NO_GRANT;
            s_data_q    <= 32'd0;
            s_sel_q     <= 1'b0;
            terr_q      <= 1'b0;
            err_q       <= 8'd0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            credit_q <= credit_d;
            timer_q  <= timer_d;
            grant_q  <= grant_d;
            s_data_q <= s_data_d;
            s_sel_q  <= s_sel_d;
            terr_q   <= terr_d;
            err_q    <= err_d;
        end
    end

    assign m_ack       = (state_q == MACK) ? (3'b001 << grant_q) : 3'b000;
    assign s_req       = (state_q == SREQ);
    assign s_data      = s_data_q;
    assign s_sel       = s_sel_q;
    assign grant_id    = grant_q;
    assign busy        = (state_q != IDLE);
    assign timeout_err = terr_q;
    assign err_count   = err_q;

endmodule

// File: tb/tb_multi_slave_wrr_scheduler.sv
// tb/tb_multi_slave_wrr_scheduler.sv - self-checking bench for multi_slave_wrr_scheduler
module tb_multi_slave_wrr_scheduler;

    localparam int P_W0 = 2;
    localparam int P_W1 = 1;
    localparam int P_W2 = 0;
    localparam int P_TO = 8;
    localparam int NEVER = 1000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  m_req;
    logic [31:0] m_data0, m_data1, m_data2;
    logic [2:0]  m_ack;
    logic        s_req;
    logic [31:0] s_data;
    logic        s_sel;
    logic        s_ack;
    logic [1:0]  grant_id;
    logic        busy;
    logic        timeout_err;
    logic [7:0]  err_count;

    always #5 clk = ~clk;

    multi_slave_wrr_scheduler #(
        .W0(P_W0), .W1(P_W1), .W2(P_W2), .TIMEOUT(P_TO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .m_req(m_req),
        .m_data0(m_data0), .m_data1(m_data1), .m_data2(m_data2),
        .m_ack(m_ack), .s_req(s_req), .s_data(s_data), .s_sel(s_sel),
        .s_ack(s_ack), .grant_id(grant_id), .busy(busy),
        .timeout_err(timeout_err), .err_count(err_count)
    );

    int checks   = 0;
    int failures = 0;

    int          ptr_m;
    int          credit_m [3];
    int          wt_m [3];
    int          err_m;
    logic [31:0] data_m [3];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        wt_m[0] = (P_W0 == 0) ? 1 : P_W0;
        wt_m[1] = (P_W1 == 0) ? 1 : P_W1;
        wt_m[2] = (P_W2 == 0) ? 1 : P_W2;
        ptr_m = 0;
        for (int i = 0; i < 3; i++) credit_m[i] = wt_m[i];
        err_m = 0;
    endtask

    function automatic int pick(input logic [2:0] mask);
        int idx;
        for (int i = 0; i < 3; i++) begin
            idx = (ptr_m + i) % 3;
            if (mask[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic model_update(input int g);
        if (credit_m[g] > 1) begin
            credit_m[g] = credit_m[g] - 1;
        end else begin
            credit_m[g] = wt_m[g];
            ptr_m = (g + 1) % 3;
        end
    endtask

    task automatic bump_err();
        err_m = (err_m < 255) ? err_m + 1 : 255;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_m_ack"}, 32'(m_ack), 32'd0);
        chk({tag, "_s_req"}, 32'(s_req), 32'd0);
        chk({tag, "_s_sel"}, 32'(s_sel), 32'd0);
        chk({tag, "_s_data"}, s_data, 32'd0);
        chk({tag, "_grant_id"}, 32'(grant_id), 32'd3);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_timeout_err"}, 32'(timeout_err), 32'd0);
        chk({tag, "_err_count"}, 32'(err_count), 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        s_ack = 1'b0;
        m_req = 3'b000;
        tick();
        check_reset_outputs("reset");
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic rand_data();
        for (int i = 0; i < 3; i++) data_m[i] = $urandom;
    endtask

    // d: edge (counted from SREQ entry) at which s_ack is first sampled high; r: same for release.
    task automatic do_txn(input logic [2:0] mask, input int d, input int r, input int hold,
                          output int g);
        logic [2:0] gbit;
        bit acked, released;
        g = pick(mask);
        gbit = 3'(1 << g);
        m_data0 = data_m[0];
        m_data1 = data_m[1];
        m_data2 = data_m[2];
        m_req = mask;
        tick();
        chk("grant_busy", 32'(busy), 32'd1);
        chk("grant_id", 32'(grant_id), 32'(g));
        chk("grant_no_sreq", 32'(s_req), 32'd0);
        tick();
        chk("sreq_rise", 32'(s_req), 32'd1);
        chk("s_data", s_data, data_m[g]);
        chk("s_sel", 32'(s_sel), 32'(data_m[g][31]));
        m_data0 = $urandom;
        m_data1 = $urandom;
        m_data2 = $urandom;
        acked = 0;
        for (int k = 1; k <= P_TO; k++) begin
            m_req = 3'($urandom) | gbit;
            if (k == d) s_ack = 1'b1;
            tick();
            if (k == d) begin
                acked = 1;
                break;
            end
            if (k < P_TO) chk("sreq_held", 32'(s_req), 32'd1);
        end
        chk("srel_sreq_low", 32'(s_req), 32'd0);
        if (!acked) begin
            chk("sreq_timeout_pulse", 32'(timeout_err), 32'd1);
            bump_err();
            tick();
            chk("pulse_one_cycle", 32'(timeout_err), 32'd0);
        end else begin
            chk("ack_no_pulse", 32'(timeout_err), 32'd0);
            released = 0;
            for (int k = 1; k <= P_TO; k++) begin
                if (k == r) s_ack = 1'b0;
                tick();
                if (k == r) begin
                    released = 1;
                    break;
                end
            end
            if (!released) begin
                chk("srel_timeout_pulse", 32'(timeout_err), 32'd1);
                bump_err();
                s_ack = 1'b0;
            end else begin
                chk("rel_no_pulse", 32'(timeout_err), 32'd0);
            end
        end
        chk("mack_ack", 32'(m_ack), 32'(gbit));
        chk("mack_busy", 32'(busy), 32'd1);
        chk("s_data_hold", s_data, data_m[g]);
        chk("err_count", 32'(err_count), 32'(err_m));
        for (int h = 0; h < hold; h++) begin
            tick();
            chk("mack_hold", 32'(m_ack), 32'(gbit));
        end
        m_req = mask & ~gbit;
        tick();
        chk("ack_drop", 32'(m_ack), 32'd0);
        chk("idle_grant_id", 32'(grant_id), 32'd3);
        chk("idle_busy", 32'(busy), 32'd0);
        model_update(g);
    endtask

    initial begin
        int g;
        int exp_wrr [8];
        int exp_w0 [4];
        rst_n = 1'b0;
        m_req = 3'b000;
        s_ack = 1'b0;
        m_data0 = 32'd0;
        m_data1 = 32'd0;
        m_data2 = 32'd0;
        model_reset();
        tick();
        do_reset();

        // Single master, slave acks after 3 cycles.
        rand_data();
        data_m[1] = 32'h8000_00AA;
        do_txn(3'b010, 3, 1, 1, g);
        chk("single_grant", 32'(g), 32'd1);
        chk("single_s_sel", 32'(s_sel), 32'd1);
        chk("single_s_data", s_data, 32'h8000_00AA);

        // All three requesting continuously.
        do_reset();
        exp_wrr = '{0, 0, 1, 2, 0, 0, 1, 2};
        for (int i = 0; i < 8; i++) begin
            rand_data();
            do_txn(3'b111, 1, 1, 0, g);
            chk("wrr_order", 32'(g), 32'(exp_wrr[i]));
        end

        // Zero weight on master 2 behaves as weight 1.
        do_reset();
        exp_w0 = '{1, 2, 1, 2};
        for (int i = 0; i < 4; i++) begin
            rand_data();
            do_txn(3'b110, 1, 2, 0, g);
            chk("w0_order", 32'(g), 32'(exp_w0[i]));
        end

        // Slave never acks.
        do_reset();
        rand_data();
        do_txn(3'b001, NEVER, 1, 0, g);
        chk("timeout_err_count", 32'(err_count), 32'd1);

        // Randomised traffic.
        for (int i = 0; i < 40; i++) begin
            logic [2:0] mask;
            mask = 3'($urandom_range(1, 7));
            rand_data();
            do_txn(mask, $urandom_range(1, 10), $urandom_range(1, 10), $urandom_range(0, 2), g);
        end

        // Reset while s_req is high, with ptr parked away from 0.
        do_reset();
        rand_data();
        do_txn(3'b010, 1, 1, 0, g);
        m_req = 3'b111;
        tick();
        chk("pre_abort_grant", 32'(grant_id), 32'd2);
        tick();
        chk("pre_abort_sreq", 32'(s_req), 32'd1);
        rst_n = 1'b0;
        tick();
        check_reset_outputs("abort");
        rst_n = 1'b1;
        model_reset();
        rand_data();
        do_txn(3'b111, 2, 1, 0, g);
        chk("post_abort_grant", 32'(g), 32'd0);

        // Error counter saturation.
        do_reset();
        for (int i = 0; i < 260; i++) begin
            rand_data();
            do_txn(3'($urandom_range(1, 7)), NEVER, 1, 0, g);
        end
        chk("err_saturated", 32'(err_count), 32'd255);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
